// File: rtl/host_rd_arbiter.sv
// host_rd_arbiter: round-robin I/D cache line-fill arbiter driving a single outstanding host read.
module host_rd_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_rd_req,
  input  logic [31:0]  i_miss_addr,
  input  logic         d_rd_req,
  input  logic [31:0]  d_miss_addr,
  output logic         host_req_valid,
  output logic [31:0]  host_req_addr,
  input  logic         host_req_ready,
  input  logic         host_rsp_valid,
  input  logic [31:0]  host_rsp_addr,
  input  logic [511:0] host_rsp_data,
  output logic         i_fill_valid,
  output logic         d_fill_valid,
  output logic [31:0]  fill_addr,
  output logic [511:0] fill_data,
  output logic         timeout_err,
  output logic         busy
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FILL} state_t;
  state_t state, state_nx;
  logic [31:0]   lat_addr;
  logic          gnt_d, last_d;
  logic [CW-1:0] cnt;
  logic          any_req, pick_d, rsp_hit, tmo;
  logic          unused_bits;
  assign unused_bits = ^{i_miss_addr[5:0], d_miss_addr[5:0], host_rsp_addr[5:0]};
  always_comb begin
    any_req  = i_rd_req | d_rd_req;
    // on a tie, D wins only if I was granted last
    pick_d   = d_rd_req & (~i_rd_req | ~last_d);
    rsp_hit  = host_rsp_valid & (host_rsp_addr[31:6] == lat_addr[31:6]);
    tmo      = 1'b0;
    state_nx = state;
    case (state)
      IDLE:    state_nx = any_req ? ISSUE : IDLE;
      ISSUE:   state_nx = host_req_ready ? WAIT : ISSUE;
      WAIT: begin
        tmo      = ~rsp_hit & (cnt == CMAX);
        state_nx = rsp_hit ? FILL : (tmo ? IDLE : WAIT);
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr  <= '0;
      gnt_d     <= 1'b0;
      last_d    <= 1'b1;
      cnt       <= '0;
      fill_addr <= '0;
      fill_data <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        lat_addr <= {(pick_d ? d_miss_addr[31:6] : i_miss_addr[31:6]), 6'b0};
        gnt_d    <= pick_d;
        last_d   <= pick_d;
      end
      if (state == ISSUE && host_req_ready) cnt <= '0;
      if (state == WAIT && cnt != CMAX) cnt <= cnt + 1'b1;
      if (state == WAIT && rsp_hit) begin
        fill_addr <= lat_addr;
        fill_data <= host_rsp_data;
      end
    end
  end
  assign host_req_valid = state == ISSUE;
  assign host_req_addr  = lat_addr;
  assign i_fill_valid   = state == FILL && !gnt_d;
  assign d_fill_valid   = state == FILL && gnt_d;
  assign timeout_err    = tmo;
  assign busy           = state != IDLE;
endmodule
